nibble_serial_alu_ctrl: RTL
===========================

Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that runs a WIDTH-bit ALU operation through a single bit4_look_ahead_carry_adder slice, one nibble per cycle, LSB nibble first.
- Latches the operands, drives the slice and its carry chain across cycles, and selects the S/AND/OR/XOR slice output per operation.
- Assembles the result and flags, then presents them on a valid/ready handshake.
- Area-reduced ALU option for the multi-cycle MIPS32/RV32I execute stage.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4, minimum 8.
- NIBBLES, WIDTH/4, derived number of slice passes; not overridden.

Ports:
- clk_in  input  1  rising-edge clock
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  request; accepted when start_in && ready_out at a rising edge
- ready_out  output  1  high only in IDLE
- op_in  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (optional), others invalid
- A_in  input  WIDTH  operand A, sampled at accept
- B_in  input  WIDTH  operand B, sampled at accept
- result_out  output  WIDTH  final result, held while valid_out is high
- C_out  output  1  final carry; for SUB this is the no-borrow flag
- overflow_out  output  1  signed overflow (ADD/SUB/SLT only, else 0)
- zero_out  output  1  result_out == 0
- valid_out  output  1  result and flags valid
- result_ready_in  input  1  consumer acknowledge

Behaviour:
- Clock and reset: single clock clk_in. rst_in is synchronous and active-high.
- Reset state: state=IDLE; result_out, C_out, overflow_out, zero_out, valid_out = 0; ready_out=1 after the reset edge.
- Reset mid-operation: rst_in during RUN or DONE aborts at that edge with the same values; a pending result is discarded.
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE, on accept:
  - Latch A and B. B is inverted for SUB/SLT.
  - Latch op; nibble count=0; carry register = 1 for SUB/SLT, else 0.
  - Go to RUN.
- RUN, each cycle with count k:
  - Drive the slice with A[4k+3:4k], latched B nibble and the carry register.
  - Write the op-selected slice output (S for ADD/SUB/SLT, AND_out, OR_out, XOR_out) into result nibble k.
  - carry register <= slice C_out; count++.
  - At k = NIBBLES-1: compute overflow = (A_msb == B'_msb) && (sum_msb != A_msb); register C_out and zero_out; go to DONE.
- Latency: the accept edge is edge 0. Nibbles are processed on edges 1..NIBBLES. valid_out is high after edge NIBBLES (8 cycles for WIDTH=32).
- DONE:
  - valid_out=1; outputs stable until result_ready_in=1 at an edge.
  - At that edge, valid_out<=0 and state returns to IDLE. Outputs keep their last values.
  - Minimum one idle cycle between operations; no back-to-back accept in DONE.
- start_in while not ready is ignored, with no queueing. A_in, B_in and op_in changes after accept have no effect.
- Logic ops: C_out=0, overflow_out=0.
- Invalid op: full NIBBLES latency; result 0, C_out=0, overflow_out=0, zero_out=1.
- Carry wraps out silently; no exception is raised on overflow.

Optional Feature:
- Macro: NIBBLE_ALU_SLT_EN.
- Defined: op 101 runs SUB internally. result_out = {WIDTH-1 zeros, sum_msb XOR overflow}, overflow_out reports the subtraction's overflow, C_out = no-borrow, zero_out from the final result.
- Undefined: op 101 is handled as an invalid op.

Test Plan:
- Basic ADD: A=0x00000009, B=0x00000003, ADD. Required: valid_out rises exactly 8 cycles after accept; result 0x0000000C, C_out=0, overflow_out=0, zero_out=0.
- ADD wrap: A=0xFFFFFFFF, B=0x00000001. Required: result 0x00000000, C_out=1, zero_out=1, overflow_out=0.
- SUB overflow: A=0x7FFFFFFF, B=0xFFFFFFFF. Required: result 0x80000000, overflow_out=1, C_out=0.
- Logic ops: A=0xF0F01234, B=0x0FF0FF00. Required: AND gives 0x00F01200, OR gives 0xFFF0FF34, XOR gives 0xFF00ED34; C_out=0 for each.
- Handshake and reset:
  - Hold result_ready_in=0 for 5 cycles in DONE: outputs stay stable.
  - start_in pulses during RUN and DONE are ignored.
  - Separately, assert rst_in at RUN count 3: next cycle state is IDLE, ready_out=1, valid_out=0, result_out=0.
- SLT: A=0xFFFFFFFF, B=0x00000001, op 101. Required: with NIBBLE_ALU_SLT_EN, result 0x00000001; without it, result 0x00000000 and zero_out=1.

Source files
------------

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial ALU sequencer around a 4-bit look-ahead carry slice.
// Optional SLT support is enabled by defining NIBBLE_ALU_SLT_EN.
module bit4_look_ahead_carry_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic [3:0] S,
    output logic       C_out,
    output logic [3:0] AND_out,
    output logic [3:0] OR_out,
    output logic [3:0] XOR_out
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;
    assign w_c[0] = C_in;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign S       = w_p ^ w_c[3:0];
    assign C_out   = w_c[4];
    assign AND_out = w_g;
    assign OR_out  = A | B;
    assign XOR_out = w_p;
endmodule

module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    output logic             ready_out,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] result_out,
    output logic             C_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             valid_out,
    input  logic             result_ready_in
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

`ifdef NIBBLE_ALU_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c;
    logic             r_ovf;
    logic             r_zero;
    logic             r_valid;

    logic [3:0]       w_s;
    logic [3:0]       w_and;
    logic [3:0]       w_or;
    logic [3:0]       w_xor;
    logic             w_c;
    logic [3:0]       w_nib;
    logic             w_arith;
    logic             w_slt;
    logic             w_sub_in;
    logic             w_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_final;

    bit4_look_ahead_carry_adder u_slice (
        .A       (r_a[3:0]),
        .B       (r_b[3:0]),
        .C_in    (r_carry),
        .S       (w_s),
        .C_out   (w_c),
        .AND_out (w_and),
        .OR_out  (w_or),
        .XOR_out (w_xor)
    );

    assign w_sub_in = (op_in == OP_SUB) || (SLT_EN && op_in == OP_SLT);
    assign w_slt    = SLT_EN && (r_op == OP_SLT);
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        w_nib   = 4'h0;
        w_arith = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_nib   = w_s;
                w_arith = 1'b1;
            end
            OP_AND: w_nib = w_and;
            OP_OR:  w_nib = w_or;
            OP_XOR: w_nib = w_xor;
            default: begin
                if (w_slt) begin
                    w_nib   = w_s;
                    w_arith = 1'b1;
                end
            end
        endcase
    end

    // Only meaningful on the top nibble, where bit 3 is the word MSB
    assign w_ovf = w_arith && (r_a[3] == r_b[3]) && (w_s[3] != r_a[3]);
    assign w_acc_next = {w_nib, r_acc[WIDTH-1:4]};
    assign w_final = w_slt ? {{(WIDTH-1){1'b0}}, w_s[3] ^ w_ovf}
                           : w_acc_next;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start_in) w_state_next = S_RUN;
            S_RUN:  if (w_last) w_state_next = S_DONE;
            S_DONE: if (result_ready_in) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_a     <= A_in;
                        r_b     <= w_sub_in ? ~B_in : B_in;
                        r_op    <= op_in;
                        r_cnt   <= '0;
                        r_carry <= w_sub_in;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_acc   <= w_acc_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res   <= w_final;
                        r_c     <= w_arith & w_c;
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_final == '0);
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready_in) r_valid <= 1'b0;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign ready_out    = (r_state == S_IDLE);
    assign result_out   = r_res;
    assign C_out        = r_c;
    assign overflow_out = r_ovf;
    assign zero_out     = r_zero;
    assign valid_out    = r_valid;
endmodule
